// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared binary32 types, constants and field helpers
package fp_pkg;

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_INF, SP_NAN} special_t;

  localparam int          EXP_BIAS = 127;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] POS_INF  = 32'h7F800000;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] f_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - round-to-nearest-even, range check and binary32 packing
module fp_round_pack
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp,
  input  logic [23:0]       sig,
  input  logic              guard,
  input  logic              sticky,
  input  special_t          special,
  output logic [31:0]       result
);

  logic              round_up;
  logic [24:0]       sig_rnd;
  logic signed [9:0] exp_rnd;
  logic [22:0]       frac;

  always_comb begin
    round_up = guard & (sticky | sig[0]);
    sig_rnd  = {1'b0, sig} + {24'd0, round_up};
    exp_rnd  = exp;
    frac     = sig_rnd[22:0];
    // carry out of rounding renormalises by one place
    if (sig_rnd[24]) begin
      frac    = sig_rnd[23:1];
      exp_rnd = exp + 10'sd1;
    end

    result = {sign, 31'd0};
    case (special)
      SP_NAN:  result = QNAN;
      SP_INF:  result = {sign, POS_INF[30:0]};
      SP_ZERO: result = {sign, 31'd0};
      default: begin
        if (exp_rnd >= 10'sd255)
          result = {sign, POS_INF[30:0]};
        else if (exp_rnd <= 10'sd0)
          result = {sign, 31'd0};
        else
          result = {sign, exp_rnd[7:0], frac};
      end
    endcase
  end

endmodule

// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - iterative binary32 multiplier, radix-2 shift-add, flush-to-zero
module fp_mul_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic        busy,
  output logic        valid_out,
  output logic [31:0] S
);

  state_t      state, state_nxt;
  logic        sign_q;
  logic [7:0]  e1_q, e2_q;
  logic [23:0] m1_q, m2_q;
  logic [47:0] acc;
  logic [4:0]  cnt;
  special_t    sp_q;
  logic [31:0] res_q;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  special_t    sp_cap;
  logic [24:0] sum;
  logic [9:0]  e_sum;
  logic [23:0] sig_norm;
  logic        guard, sticky;
  logic [31:0] packed_res;

  always_comb begin
    ea     = f_exp(num1);
    eb     = f_exp(num2);
    fa     = f_frac(num1);
    fb     = f_frac(num2);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      sp_cap = SP_NAN;
    else if (a_inf || b_inf)
      sp_cap = SP_INF;
    else if (a_zero || b_zero)
      sp_cap = SP_ZERO;
    else
      sp_cap = SP_NONE;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MULT;
      MULT:    if (cnt == 5'd23) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign sum = {1'b0, acc[47:24]} + (m2_q[0] ? {1'b0, m1_q} : 25'd0);

  // product lies in [1,4): bit 47 set means one extra exponent step
  always_comb begin
    e_sum = {2'b00, e1_q} + {2'b00, e2_q} - 10'(EXP_BIAS);
    if (acc[47]) begin
      sig_norm = acc[47:24];
      guard    = acc[23];
      sticky   = |acc[22:0];
      e_sum    = e_sum + 10'd1;
    end else begin
      sig_norm = acc[46:23];
      guard    = acc[22];
      sticky   = |acc[21:0];
    end
  end

  fp_round_pack u_round_pack (
    .sign    (sign_q),
    .exp     ($signed(e_sum)),
    .sig     (sig_norm),
    .guard   (guard),
    .sticky  (sticky),
    .special (sp_q),
    .result  (packed_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q    <= 1'b0;
      e1_q      <= 8'd0;
      e2_q      <= 8'd0;
      m1_q      <= 24'd0;
      m2_q      <= 24'd0;
      acc       <= 48'd0;
      cnt       <= 5'd0;
      sp_q      <= SP_NONE;
      res_q     <= 32'd0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      S         <= 32'd0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            sign_q <= f_sign(num1) ^ f_sign(num2);
            e1_q   <= ea;
            e2_q   <= eb;
            m1_q   <= a_zero ? 24'd0 : {1'b1, fa};
            m2_q   <= b_zero ? 24'd0 : {1'b1, fb};
            acc    <= 48'd0;
            cnt    <= 5'd0;
            sp_q   <= sp_cap;
          end
        end
        MULT: begin
          acc  <= {sum, acc[23:1]};
          m2_q <= {1'b0, m2_q[23:1]};
          cnt  <= cnt + 5'd1;
        end
        NORM: res_q <= packed_res;
        DONE: begin
          S         <= res_q;
          valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_mul_seq.md
# fp_mul_seq

Iterative IEEE-754 single-precision multiplier. It is the inverse-operation companion to the sequential divider in the ALU, and shares the same operand/result naming and the `valid_out` completion flag. The significand product is formed by a radix-2 shift-add loop, one bit per cycle. The result is then normalised, rounded to nearest-even and packed. Denormals are flushed to zero.

## Interface
- No parameters; format fixed at binary32.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- num1  in  32  multiplicand, binary32; captured on the start edge
- num2  in  32  multiplier, binary32; captured on the start edge
- busy  out  1  high from the capture edge until `valid_out` drops
- valid_out  out  1  one-cycle pulse; `S` is valid while high
- S  out  32  product, held until the next `valid_out`

## Operation
- States: IDLE, MULT, NORM, DONE.
- **IDLE**
  - On `start`: latch the signs and exponents; extend each significand to 24 bits with the hidden bit.
  - Either exponent of 0 makes that operand zero; its fraction is ignored (flush-to-zero).
  - Clear the 48-bit accumulator and the 5-bit counter, then go to MULT.
- **MULT**, 24 cycles
  - If the multiplier LSB is 1, add the multiplicand to the upper accumulator half.
  - Shift the {carry, accumulator} right by 1; shift the multiplier right by 1.
  - When the counter reaches 23, go to NORM.
- **NORM**, 1 cycle
  - Exponent: `e = e1 + e2 - 127`, computed 10-bit signed.
  - If product bit 47 is set: take bits 47:24 as the significand and increment `e`.
  - Guard bit = next bit below the significand; sticky = OR of all remaining bits.
  - Round to nearest-even: increment when guard is set and (sticky or the significand LSB) is set.
  - If rounding carries out, shift the significand right by 1 and increment `e`.
- **Overflow/underflow**
  - `e >= 255` gives ±Inf.
  - `e <= 0` gives ±0 (no denormal output).
- **Special operands**, resolved at capture; MULT still runs, so latency stays uniform.
  - NaN × any, or Inf × 0: result 0x7FC00000.
  - Inf × nonzero: ±Inf.
  - 0 × finite: ±0.
  - Sign is always `s1 ^ s2`, except for NaN.
- **DONE**: drive `S`, assert `valid_out` for one cycle, return to IDLE.
- `start` in any state other than IDLE is ignored. The captured operands are not affected by later changes to `num1`/`num2`.

## Timing
- Reset value of every output is 0: `busy`, `valid_out`, `S`. State returns to IDLE and internal registers clear.
- `rst` asserted mid-operation aborts with no `valid_out`.
- **Latency:** capture edge T0 → MULT occupies edges T1..T24 → NORM at T25 → DONE (`valid_out` high) after T26. `valid_out` falls after T27.
- `busy` rises after T0 and falls together with `valid_out`.
- **Back-to-back:** a `start` held at T27 is captured at T27, giving a throughput of one op per 27 cycles.
- `S` changes only on the edge that raises `valid_out`.

## Structure
- Shared package `fp_pkg` (shared with the divider):
  - state enum type
  - `EXP_BIAS = 127`
  - `QNAN = 32'h7FC00000`
  - `POS_INF = 32'h7F800000`
  - binary32 field-extract functions (sign/exponent/fraction)
- One sub-module, `fp_round_pack`, purely combinational:
  - inputs: sign, 10-bit exponent, 24-bit significand, guard, sticky, special-case code
  - output: 32-bit packed result
  - the divider also uses it.
- The FSM, accumulator and counter live in `fp_mul_seq`.

## Test plan
- Basic: 0x3FC00000 × 0x40000000 (1.5×2) → S = 0x40400000; `valid_out` exactly 26 cycles after the start edge; `busy` high throughout.
- Sign and normalisation shift: 0xC0000000 × 0x3F400000 → 0xBFC00000; 0x3FC00000 × 0x3FC00000 → 0x40100000.
- Rounding:
  - 0x3F800001 × 0x3F800001 → 0x3F800002 (guard 0, sticky set: no round-up).
  - 0x3F800001 × 0x3FC00000 → 0x3FC00002 (tie, rounds to even).
- Specials:
  - 0x7F000000 × 0x7F000000 → 0x7F800000 (overflow to Inf).
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0x00800000 × 0x00800000 → 0x00000000 (underflow).
  - 0x80000000 × 0x3F800000 → 0x80000000 (signed zero).
- Handshake:
  - `start` pulsed at cycle 5 of a busy operation, with different operands → ignored; first result unchanged.
  - `start` held continuously → one result every 27 cycles.
- Reset mid-op: assert `rst` 10 cycles into MULT → all outputs 0 immediately, no `valid_out`; a new start after release gives the correct result at +26.
